// File: rtl/instr_sequencer.sv
// Program sequencer: fetches 32-bit words and resolves HALT/JUMP/LOOP/ENDLOOP
// locally with a bounded hardware loop stack. It forwards all other words over valid/ready.
module instr_sequencer #(
  parameter int INSTR_BIT  = 8,
  parameter int LOOP_DEPTH = 4,
  parameter int COUNT_BIT  = 8
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             St,
  input  logic                             jump,
  output logic [INSTR_BIT-1:0]             imem_addr,
  input  logic [31:0]                      imem_data,
  output logic                             exec_valid,
  output logic [31:0]                      exec_instr,
  input  logic                             exec_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [$clog2(LOOP_DEPTH+1)-1:0]  loop_level
);

  localparam int LVL_W = $clog2(LOOP_DEPTH + 1);
  localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  localparam logic [3:0] OP_JUMP    = 4'hC;
  localparam logic [3:0] OP_ENDLOOP = 4'hD;
  localparam logic [3:0] OP_LOOP    = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam logic [INSTR_BIT-1:0] PC_ONE  = INSTR_BIT'(1);
  localparam logic [COUNT_BIT-1:0] CNT_ONE = COUNT_BIT'(1);
  localparam logic [LVL_W-1:0]     LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0]     LVL_MAX = LVL_W'(LOOP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [INSTR_BIT-1:0] pc_q, pc_d;
  logic [LVL_W-1:0]     sp_q, sp_d;

  logic [INSTR_BIT-1:0] stk_start [LOOP_DEPTH];
  logic [COUNT_BIT-1:0] stk_rem   [LOOP_DEPTH];

  logic [3:0]           opcode;
  logic                 is_seq;
  logic [IDX_W-1:0]     top_idx;
  logic [IDX_W-1:0]     push_idx;
  logic [INSTR_BIT-1:0] top_start;
  logic [COUNT_BIT-1:0] top_rem;
  logic [COUNT_BIT-1:0] loop_cnt;
  logic                 stack_full;
  logic                 stack_empty;
  logic                 pc_at_max;
  logic                 push_en;
  logic                 dec_en;
  logic                 advance;

  assign opcode      = imem_data[31:28];
  assign is_seq      = opcode[3] & opcode[2];
  assign top_idx     = IDX_W'(sp_q - LVL_ONE);
  assign push_idx    = IDX_W'(sp_q);
  assign top_start   = stk_start[top_idx];
  assign top_rem     = stk_rem[top_idx];
  assign loop_cnt    = imem_data[COUNT_BIT-1:0];
  assign stack_full  = (sp_q == LVL_MAX);
  assign stack_empty = (sp_q == '0);
  assign pc_at_max   = &pc_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    push_en = 1'b0;
    dec_en  = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (St) begin
          state_d = S_RUN;
          pc_d    = '0;
          sp_d    = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_RUN: begin
        unique case (opcode)
          OP_HALT: state_d = S_DONE;
          OP_JUMP: begin
            if (jump) pc_d = imem_data[INSTR_BIT-1:0];
            else      advance = 1'b1;
          end
          OP_LOOP: begin
            if (stack_full) begin
              state_d = S_ERR;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + LVL_ONE;
              advance = 1'b1;
            end
          end
          OP_ENDLOOP: begin
            if (stack_empty) begin
              state_d = S_ERR;
            end else if (top_rem > CNT_ONE) begin
              dec_en = 1'b1;
              pc_d   = top_start;
            end else begin
              sp_d    = sp_q - LVL_ONE;
              advance = 1'b1;
            end
          end
          default: advance = exec_ready;
        endcase

        // Stepping past the last word is a fault; the stack is left untouched.
        if (advance) begin
          if (pc_at_max) begin
            state_d = S_ERR;
            sp_d    = sp_q;
            push_en = 1'b0;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: stack storage has no reset; sp_q alone decides which entries are live.
    if (push_en) begin
      stk_start[push_idx] <= pc_q + PC_ONE;
      stk_rem[push_idx]   <= (loop_cnt == '0) ? CNT_ONE : loop_cnt;
    end else if (dec_en) begin
      stk_rem[top_idx] <= top_rem - CNT_ONE;
    end
  end

  assign imem_addr  = pc_q;
  assign exec_valid = (state_q == S_RUN) && !is_seq;
  assign exec_instr = exec_valid ? imem_data : '0;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign loop_level = sp_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random programs checked
// against a program interpreter that works on whole instructions and a queue stack.
module tb_instr_sequencer;

  localparam int IB  = 8;
  localparam int LD  = 4;
  localparam int CB  = 8;
  localparam int LW  = $clog2(LD + 1);

  logic          CLK = 1'b0;
  logic          RST, St, jump, exec_ready;
  logic [IB-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          exec_valid;
  logic [31:0]   exec_instr;
  logic          busy, done, error;
  logic [LW-1:0] loop_level;

  logic [31:0]   imem [256];

  instr_sequencer #(.INSTR_BIT(IB), .LOOP_DEPTH(LD), .COUNT_BIT(CB)) dut (
    .CLK(CLK), .RST(RST), .St(St), .jump(jump),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .exec_valid(exec_valid), .exec_instr(exec_instr), .exec_ready(exec_ready),
    .busy(busy), .done(done), .error(error), .loop_level(loop_level)
  );

  assign imem_data = imem[imem_addr];
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference interpreter results.
  logic [31:0] exp_fwd [$];
  bit          exp_err;
  int          exp_steps;
  int          exp_peak;
  int          exp_end_lvl;

  // Results of the last DUT run.
  int last_cycles, last_nfwd, last_peak;

  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < 256; i++) imem[i] = w;
  endtask

  task automatic model_run(input bit jmp);
    int pc;
    int st_start [$];
    int st_rem [$];
    logic [31:0] w;
    int cnt;
    bit adv;
    exp_fwd.delete();
    exp_err = 0; exp_steps = 0; exp_peak = 0; exp_end_lvl = 0; pc = 0;
    forever begin
      if (exp_steps >= 2000) begin exp_steps = -1; return; end
      w = imem[pc];
      exp_steps++;
      adv = 0;
      case (w[31:28])
        4'hF: begin exp_end_lvl = st_rem.size(); return; end
        4'hC: if (jmp) pc = int'(w[7:0]); else adv = 1;
        4'hE: begin
          if (st_rem.size() == LD) begin exp_err = 1; return; end
          cnt = int'(w[7:0]);
          st_start.push_back(pc + 1);
          st_rem.push_back(cnt == 0 ? 1 : cnt);
          adv = 1;
        end
        4'hD: begin
          if (st_rem.size() == 0) begin exp_err = 1; return; end
          if (st_rem[st_rem.size()-1] > 1) begin
            st_rem[st_rem.size()-1] = st_rem[st_rem.size()-1] - 1;
            pc = st_start[st_start.size()-1];
          end else begin
            void'(st_rem.pop_back());
            void'(st_start.pop_back());
            adv = 1;
          end
        end
        default: begin exp_fwd.push_back(w); adv = 1; end
      endcase
      if (adv) begin
        if (pc == 255) begin exp_err = 1; return; end
        pc++;
      end
      if (st_rem.size() > exp_peak) exp_peak = st_rem.size();
    end
  endtask

  task automatic start_run();
    St = 1'b1;
    @(posedge CLK); #1;
    St = 1'b0;
  endtask

  task automatic run_prog(input bit rand_ready, input bit jmp, input string tag);
    logic [31:0] got [$];
    int c, budget, bad;
    bit finished, prev_stall;
    logic [IB-1:0] prev_addr;
    logic [31:0] prev_instr;
    model_run(jmp);
    budget = 4 * exp_steps + 20;
    jump = jmp;
    start_run();
    finished = 0; prev_stall = 0; last_peak = 0;
    prev_addr = '0; prev_instr = '0;
    for (c = 1; c <= budget; c++) begin
      if (prev_stall) begin
        check({tag, " stall_valid"}, exec_valid, 1'b1);
        check({tag, " stall_addr"}, imem_addr, prev_addr);
        check({tag, " stall_instr"}, exec_instr, prev_instr);
      end
      if (int'(loop_level) > last_peak) last_peak = int'(loop_level);
      if (done || error) begin finished = 1; break; end
      exec_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (exec_valid && exec_ready) got.push_back(exec_instr);
      prev_stall = exec_valid && !exec_ready;
      prev_addr  = imem_addr;
      prev_instr = exec_instr;
      @(posedge CLK); #1;
    end
    last_cycles = c;
    last_nfwd   = got.size();
    check({tag, " finished"}, finished, 1'b1);
    check({tag, " error"}, error, exp_err);
    check({tag, " done"}, done, !exp_err);
    check({tag, " nfwd"}, got.size(), exp_fwd.size());
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_fwd.size(); i++)
      if (got[i] !== exp_fwd[i]) bad++;
    check({tag, " words_bad"}, bad, 0);
    check({tag, " peak"}, last_peak, exp_peak);
    if (!rand_ready) check({tag, " cycles"}, c, exp_steps + 1);
    if (!exp_err) check({tag, " lvl_at_halt"}, loop_level, exp_end_lvl);
    @(posedge CLK); #1;
    if (exp_err) begin
      check({tag, " err_sticky"}, error, 1'b1);
      check({tag, " err_busy"}, busy, 1'b0);
    end else begin
      check({tag, " done_pulse"}, done, 1'b0);
      check({tag, " idle_busy"}, busy, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " error"}, error, 1'b0);
    check({tag, " exec_valid"}, exec_valid, 1'b0);
    check({tag, " loop_level"}, loop_level, '0);
    check({tag, " imem_addr"}, imem_addr, '0);
  endtask

  initial begin
    int k, r;
    logic [31:0] w;
    bit jmp, saw_done;
    RST = 1'b1; St = 1'b0; jump = 1'b0; exec_ready = 1'b0;
    fill(32'hF000_0000);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check_all_zero("reset");

    // Straight line.
    imem[0] = 32'hA000_0001; imem[1] = 32'hA000_0002; imem[2] = 32'hF000_0000;
    run_prog(0, 1, "straight");
    check("straight nfwd_const", last_nfwd, 2);
    check("straight done_cycle", last_cycles, 4);

    // Stall on one execute word.
    fill(32'hF000_0000);
    imem[0] = 32'h1000_0005;
    start_run();
    for (int i = 0; i < 4; i++) begin
      check("stall addr", imem_addr, '0);
      check("stall instr", exec_instr, 32'h1000_0005);
      exec_ready = (i == 3);
      @(posedge CLK); #1;
    end
    check("stall pc_after", imem_addr, IB'(1));
    @(posedge CLK); #1;
    check("stall done", done, 1'b1);
    @(posedge CLK); #1;

    // Nested loop and zero-count loop.
    fill(32'hF000_0000);
    imem[0] = 32'hE000_0003; imem[1] = 32'hE000_0002; imem[2] = 32'h2000_0000;
    imem[3] = 32'hD000_0000; imem[4] = 32'hD000_0000;
    run_prog(0, 1, "nest");
    check("nest nfwd_const", last_nfwd, 6);
    check("nest peak_const", last_peak, 2);
    fill(32'hF000_0000);
    imem[0] = 32'hE000_0000; imem[1] = 32'h2000_0000; imem[2] = 32'hD000_0000;
    run_prog(0, 1, "count0");
    check("count0 nfwd_const", last_nfwd, 1);

    // Jump gating.
    for (int j = 1; j >= 0; j--) begin
      fill(32'hF000_0000);
      imem[0] = 32'hA000_0001; imem[1] = 32'hC000_0004;
      jump = 1'(j); exec_ready = 1'b1;
      start_run();
      @(posedge CLK); #1;
      check("jump at_pc1", imem_addr, IB'(1));
      check("jump no_valid", exec_valid, 1'b0);
      @(posedge CLK); #1;
      check("jump next_pc", imem_addr, (j != 0) ? IB'(4) : IB'(2));
      repeat (2) @(posedge CLK); #1;
    end

    // Faults: bare ENDLOOP, then stack overflow followed by a restart.
    fill(32'hF000_0000);
    imem[0] = 32'hD000_0000;
    run_prog(0, 1, "bare_end");
    fill(32'hF000_0000);
    for (int i = 0; i <= LD; i++) imem[i] = 32'hE000_0002;
    run_prog(0, 1, "overflow");
    check("overflow err_const", error, 1'b1);
    start_run();
    check("restart error", error, 1'b0);
    check("restart busy", busy, 1'b1);
    check("restart addr", imem_addr, '0);
    check("restart level", loop_level, '0);
    RST = 1'b1; @(posedge CLK); #1 RST = 1'b0;

    // Running off the end of program space.
    for (int i = 0; i < 256; i++) imem[i] = 32'h5000_0000 | i;
    run_prog(0, 1, "pc_end");
    check("pc_end nfwd_const", last_nfwd, 256);

    // Reset during a stall inside a depth-2 loop.
    fill(32'hF000_0000);
    imem[0] = 32'hE000_0002; imem[1] = 32'hE000_0002; imem[2] = 32'h3000_0000;
    imem[3] = 32'hD000_0000; imem[4] = 32'hD000_0000;
    exec_ready = 1'b1;
    start_run();
    k = 0;
    while (imem_addr != IB'(2) && k < 10) begin @(posedge CLK); #1; k++; end
    check("rst_mid reached", imem_addr, IB'(2));
    exec_ready = 1'b0;
    @(posedge CLK); #1;
    check("rst_mid level", loop_level, LW'(2));
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_all_zero("rst_mid");
    saw_done = 0;
    repeat (5) begin @(posedge CLK); #1; if (done || busy) saw_done = 1; end
    check("rst_mid quiet", saw_done, 1'b0);

    // Random programs.
    for (int p = 0; p < 40; p++) begin
      jmp = 1'($urandom_range(0, 1));
      do begin
        fill(32'hF000_0000);
        for (k = 0; k < 24; k++) begin
          r = $urandom_range(0, 99);
          if (r < 50) begin
            w = $urandom;
            w[31:28] = 4'($urandom_range(0, 11));
          end else if (r < 65) w = 32'hE000_0000 | $urandom_range(0, 3);
          else if (r < 80)     w = 32'hD000_0000;
          else if (r < 92)     w = 32'hC000_0000 | (k + 1 + $urandom_range(0, 3));
          else                 w = 32'hF000_0000;
          imem[k] = w;
        end
        model_run(jmp);
      end while (exp_steps < 0);
      run_prog($urandom_range(0, 3) != 0, jmp, $sformatf("rand%0d", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
